// File: rtl/muldiv_pkg.sv
// Shared encodings and helpers for the multi-cycle MIPS multiply/divide unit.
package muldiv_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } md_state_e;

  // Iteration counter must hold 0 .. width-1.
  function automatic int md_cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One shift-add (multiply) or restoring-subtract (divide) iteration, purely combinational.
// The divide half is only built when MULDIV_DIV_EN is defined.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] opnd_i,
  input  logic             div_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             q_bit_o
);

  logic [WIDTH:0] sum;

`ifdef MULDIV_DIV_EN
  logic [WIDTH:0]   rem_s;
  logic [WIDTH+1:0] diff;
  logic             ge;
  logic             unused_div_bits;

  assign rem_s = {hi_i, lo_i[WIDTH-1]};
  assign diff  = {1'b0, rem_s} - {2'b00, opnd_i};
  assign ge    = ~diff[WIDTH+1];
  assign unused_div_bits = diff[WIDTH] ^ rem_s[WIDTH];
`else
  logic unused_div;
  assign unused_div = div_i;
`endif

  always_comb begin
    sum     = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opnd_i} : {(WIDTH+1){1'b0}});
    hi_o    = sum[WIDTH:1];
    lo_o    = {sum[0], lo_i[WIDTH-1:1]};
    q_bit_o = 1'b0;
`ifdef MULDIV_DIV_EN
    // Remainder stays below the divisor, so the restored value fits in WIDTH bits.
    if (div_i) begin
      hi_o    = ge ? diff[WIDTH-1:0] : rem_s[WIDTH-1:0];
      lo_o    = {lo_i[WIDTH-2:0], ge};
      q_bit_o = ge;
    end
`endif
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// MULT/MULTU/DIV/DIVU sequencer owning HI/LO; one iteration per cycle.
// Divide support is compiled in only when MULDIV_DIV_EN is defined.
//
// state | meaning
// IDLE  | waiting for Start; MTHI/MTLO writes allowed
// RUN   | one step per cycle, WIDTH steps
// FIX   | sign correction, write HI/LO, pulse Done
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             HiWrEn,
  input  logic             LoWrEn,
  input  logic [WIDTH-1:0] WrData,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = md_cnt_width(WIDTH);
  localparam logic [1:0] S_IDLE = 2'(ST_IDLE);
  localparam logic [1:0] S_RUN  = 2'(ST_RUN);
  localparam logic [1:0] S_FIX  = 2'(ST_FIX);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, opnd_q, opnd_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             is_div_q, is_div_d, neg_res_q, neg_res_d, done_q, done_d;

  logic             signed_op, a_neg, b_neg, op_div, accept;
  logic [WIDTH-1:0] mag_a, mag_b, step_hi, step_lo;
  logic             step_q;
  logic             unused_qbit;
  logic [2*WIDTH-1:0] prod, prod_fix;

  assign signed_op = ~Op[0];
  assign a_neg     = signed_op & A[WIDTH-1];
  assign b_neg     = signed_op & B[WIDTH-1];
  assign mag_a     = a_neg ? -A : A;
  assign mag_b     = b_neg ? -B : B;

`ifdef MULDIV_DIV_EN
  logic             rem_neg_q, rem_neg_d, bzero_q, bzero_d, dz_q, dz_d;
  logic [WIDTH-1:0] a_orig_q, a_orig_d;
  assign op_div  = Op[1];
  assign accept  = Start;
  assign DivZero = dz_q;
`else
  assign op_div  = 1'b0;
  assign accept  = Start & ~Op[1];
  assign DivZero = 1'b0;
`endif

  assign prod     = {acc_hi_q, acc_lo_q};
  assign prod_fix = neg_res_q ? -prod : prod;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .hi_i    (acc_hi_q),
    .lo_i    (acc_lo_q),
    .opnd_i  (opnd_q),
    .div_i   (is_div_q),
    .hi_o    (step_hi),
    .lo_o    (step_lo),
    .q_bit_o (step_q)
  );
  assign unused_qbit = step_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
`ifdef MULDIV_DIV_EN
    rem_neg_d = rem_neg_q;
    bzero_d   = bzero_q;
    a_orig_d  = a_orig_q;
    dz_d      = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (HiWrEn) hi_d = WrData;
        if (LoWrEn) lo_d = WrData;
        if (accept) begin
          state_d   = S_RUN;
          cnt_d     = '0;
          acc_hi_d  = '0;
          acc_lo_d  = op_div ? mag_a : mag_b;
          opnd_d    = op_div ? mag_b : mag_a;
          is_div_d  = op_div;
          neg_res_d = a_neg ^ b_neg;
`ifdef MULDIV_DIV_EN
          rem_neg_d = a_neg;
          bzero_d   = (B == '0);
          a_orig_d  = A;
`endif
        end
      end
      S_RUN: begin
        acc_hi_d = step_hi;
        acc_lo_d = step_lo;
        if (cnt_q == CW'(WIDTH-1)) state_d = S_FIX;
        else cnt_d = cnt_q + 1'b1;
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        {hi_d, lo_d} = prod_fix;
`ifdef MULDIV_DIV_EN
        if (is_div_q) begin
          if (bzero_q) begin
            hi_d = a_orig_q;
            lo_d = '1;
            dz_d = 1'b1;
          end else begin
            lo_d = neg_res_q ? -acc_lo_q : acc_lo_q;
            hi_d = rem_neg_q ? -acc_hi_q : acc_hi_q;
          end
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

`ifdef MULDIV_DIV_EN
  always_ff @(posedge CLK) begin
    if (Reset) begin
      rem_neg_q <= 1'b0;
      bzero_q   <= 1'b0;
      a_orig_q  <= '0;
      dz_q      <= 1'b0;
    end else begin
      rem_neg_q <= rem_neg_d;
      bzero_q   <= bzero_d;
      a_orig_q  <= a_orig_d;
      dz_q      <= dz_d;
    end
  end
`endif

  assign Busy = (state_q != S_IDLE);
  assign Done = done_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule
